// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types for the fx68k bus controller: region and FSM encodings plus the
// address-nibble region decoder.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        REG_ROM  = 3'd0,
        REG_RAM  = 3'd1,
        REG_LED  = 3'd2,
        REG_ACIA = 3'd3,
        REG_GPIO = 3'd4,
        REG_NONE = 3'd5
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        VPA,
        BERR,
        DONE
    } state_t;

    localparam int ADDR_REGION_MSB = 15;
    localparam int ADDR_REGION_LSB = 12;
    localparam int WAIT_CTR_W      = 4;

    function automatic region_t decodeRegion(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return REG_ROM;
            4'h1:    return REG_RAM;
            4'h2:    return REG_LED;
            4'h3:    return REG_ACIA;
            4'h4:    return REG_GPIO;
            default: return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// CPU-facing bus signals of the fx68k plus the memory/peripheral selects the
// controller derives from them.
interface m68k_bus_ctrl_if;
    logic        as_n;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [23:1] addr;
    logic        dtack_n;
    logic        vpa_n;
    logic        berr_n;
    logic        rom_cs;
    logic        ram_cs;
    logic        ram_we;
    logic [1:0]  ram_mask;
    logic [2:0]  per_sel;

    modport master (
        output as_n, rw, uds_n, lds_n, addr,
        input  dtack_n, vpa_n, berr_n
    );

    modport slave (
        input  as_n, rw, uds_n, lds_n, addr,
        output dtack_n, vpa_n, berr_n, rom_cs, ram_cs, ram_we, ram_mask, per_sel
    );
endinterface

// File: rtl/m68k_bus_ctrl_bus_wait_ctr.sv
// Loadable saturating counter with a terminal flag; counts down to TERMINAL for
// wait states or up to TERMINAL for the bus-error timeout.
module bus_wait_ctr #(
    parameter int               WIDTH    = 4,
    parameter bit               COUNT_UP = 1'b0,
    parameter logic [WIDTH-1:0] TERMINAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    input  logic             i_en,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    assign o_terminal = (r_count == TERMINAL);

    // Holding at TERMINAL keeps the terminal flag stable until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en && !o_terminal) begin
            if (COUNT_UP) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// fx68k bus controller: region decode, wait states, registered DTACK/VPA/BERR and
// a one-clock RAM write strobe. Optional macro BUS_WATCHDOG_EN enables the BERR timeout.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int ROM_WAIT     = 0,
    parameter int RAM_WAIT     = 0,
    parameter int BERR_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    m68k_bus_ctrl_if.slave        io_bus
);

    if (ROM_WAIT < 0 || ROM_WAIT > 15) begin : g_romWaitRange
        $error("ROM_WAIT must be 0..15");
    end
    if (RAM_WAIT < 0 || RAM_WAIT > 15) begin : g_ramWaitRange
        $error("RAM_WAIT must be 0..15");
    end
    if (BERR_TIMEOUT < 1 || BERR_TIMEOUT > 65535) begin : g_berrRange
        $error("BERR_TIMEOUT must be 1..65535");
    end

    state_t                r_state;
    state_t                w_nextState;
    region_t               r_region;
    region_t               w_addrRegion;
    region_t               w_cycleRegion;
    logic                  r_rw;
    logic                  w_cycleRw;
    logic                  w_cycleStart;
    logic                  w_ackEntry;
    logic [1:0]            r_ramMask;
    logic                  r_dtackN;
    logic                  r_vpaN;
    logic                  r_ramWe;
    logic                  w_waitLoad;
    logic [WAIT_CTR_W-1:0] w_waitLoadVal;
    logic                  w_waitTerm;
    logic                  w_unusedAddr;

    assign w_addrRegion = decodeRegion(io_bus.addr[ADDR_REGION_MSB:ADDR_REGION_LSB]);
    assign w_unusedAddr = ^{io_bus.addr[23:16], io_bus.addr[11:1]};
    assign w_cycleStart = (r_state == IDLE) && !io_bus.as_n;

    // Entry into ACK can come straight from IDLE, before region/rw are latched.
    assign w_cycleRegion = (r_state == IDLE) ? w_addrRegion : r_region;
    assign w_cycleRw     = (r_state == IDLE) ? io_bus.rw    : r_rw;

    bus_wait_ctr #(
        .WIDTH    (WAIT_CTR_W),
        .COUNT_UP (1'b0),
        .TERMINAL ('0)
    ) u_waitCtr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_waitLoad),
        .i_loadVal  (w_waitLoadVal),
        .i_en       (r_state == WAIT),
        .o_terminal (w_waitTerm)
    );

`ifdef BUS_WATCHDOG_EN
    localparam int BERR_W = (BERR_TIMEOUT > 1) ? $clog2(BERR_TIMEOUT) : 1;

    logic w_berrTerm;
    logic r_berrN;

    bus_wait_ctr #(
        .WIDTH    (BERR_W),
        .COUNT_UP (1'b1),
        .TERMINAL (BERR_W'(BERR_TIMEOUT - 1))
    ) u_berrCtr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state != BERR),
        .i_loadVal  ('0),
        .i_en       (r_state == BERR),
        .o_terminal (w_berrTerm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_berrN <= 1'b1;
        end else begin
            r_berrN <= !((r_state == BERR) && (w_nextState == BERR) && w_berrTerm);
        end
    end

    assign io_bus.berr_n = r_berrN;
`else
    assign io_bus.berr_n = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_waitLoad    = 1'b0;
        w_waitLoadVal = '0;
        case (r_state)
            IDLE: begin
                if (!io_bus.as_n) begin
                    case (w_addrRegion)
                        REG_ROM: begin
                            if (ROM_WAIT == 0) begin
                                w_nextState = ACK;
                            end else begin
                                w_waitLoad    = 1'b1;
                                w_waitLoadVal = WAIT_CTR_W'(ROM_WAIT - 1);
                                w_nextState   = WAIT;
                            end
                        end
                        REG_RAM: begin
                            if (RAM_WAIT == 0) begin
                                w_nextState = ACK;
                            end else begin
                                w_waitLoad    = 1'b1;
                                w_waitLoadVal = WAIT_CTR_W'(RAM_WAIT - 1);
                                w_nextState   = WAIT;
                            end
                        end
                        REG_LED, REG_ACIA, REG_GPIO: w_nextState = VPA;
`ifdef BUS_WATCHDOG_EN
                        default: w_nextState = BERR;
`else
                        default: w_nextState = ACK;
`endif
                    endcase
                end
            end
            WAIT: begin
                if (io_bus.as_n) begin
                    w_nextState = DONE;
                end else if (w_waitTerm) begin
                    w_nextState = ACK;
                end
            end
            ACK, VPA, BERR: begin
                if (io_bus.as_n) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_ackEntry = (w_nextState == ACK) && (r_state != ACK);

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region  <= REG_NONE;
            r_rw      <= 1'b1;
            r_ramMask <= 2'b00;
            r_dtackN  <= 1'b1;
            r_vpaN    <= 1'b1;
            r_ramWe   <= 1'b0;
        end else begin
            r_dtackN <= !(w_nextState == ACK);
            r_vpaN   <= !(w_nextState == VPA);
            r_ramWe  <= w_ackEntry && (w_cycleRegion == REG_RAM) && !w_cycleRw;
            if (w_cycleStart) begin
                r_region  <= w_addrRegion;
                r_rw      <= io_bus.rw;
                r_ramMask <= {!io_bus.uds_n, !io_bus.lds_n};
            end
        end
    end

    assign io_bus.dtack_n  = r_dtackN;
    assign io_bus.vpa_n    = r_vpaN;
    assign io_bus.ram_we   = r_ramWe;
    assign io_bus.ram_mask = r_ramMask;
    assign io_bus.rom_cs   = !io_bus.as_n && (w_addrRegion == REG_ROM);
    assign io_bus.ram_cs   = !io_bus.as_n && (w_addrRegion == REG_RAM);
    assign io_bus.per_sel  = io_bus.as_n ? 3'b000 :
                             {w_addrRegion == REG_GPIO, w_addrRegion == REG_ACIA, w_addrRegion == REG_LED};

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Self-checking bench for m68k_bus_ctrl: directed bus cycles followed by random ones,
// each predicted from per-region latency and acknowledge type.
module tb_m68k_bus_ctrl;

    localparam int ROM_WAIT     = 0;
    localparam int RAM_WAIT     = 3;
    localparam int BERR_TIMEOUT = 16;
`ifdef BUS_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    localparam int KIND_DTACK = 0;
    localparam int KIND_VPA   = 1;
    localparam int KIND_BERR  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    bit   inDone     = 1'b0;

    m68k_bus_ctrl_if bus();

    m68k_bus_ctrl #(
        .ROM_WAIT     (ROM_WAIT),
        .RAM_WAIT     (RAM_WAIT),
        .BERR_TIMEOUT (BERR_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] busOuts();
        return {bus.dtack_n, bus.vpa_n, bus.berr_n, bus.ram_we};
    endfunction

    function automatic logic [4:0] selOuts();
        return {bus.rom_cs, bus.ram_cs, bus.per_sel};
    endfunction

    // Clocks from the AS sample edge until the acknowledge becomes visible.
    function automatic int latencyOf(input int region);
        case (region)
            0:       return ROM_WAIT + 1;
            1:       return RAM_WAIT + 1;
            2, 3, 4: return 1;
            default: return WDOG ? BERR_TIMEOUT + 1 : 1;
        endcase
    endfunction

    function automatic int kindOf(input int region);
        if (region >= 2 && region <= 4) return KIND_VPA;
        if (region >= 5 && WDOG)        return KIND_BERR;
        return KIND_DTACK;
    endfunction

    function automatic logic [4:0] expSel(input int region);
        case (region)
            0:       return 5'b10000;
            1:       return 5'b01000;
            2:       return 5'b00001;
            3:       return 5'b00010;
            4:       return 5'b00100;
            default: return 5'b00000;
        endcase
    endfunction

    // One complete bus cycle: idle gap, AS low for 'hold' clocks, then release.
    task automatic applyStimulus(input logic [23:0] byteAddr, input bit rwIn, input bit udsIn,
                                 input bit ldsIn, input int hold, input int gap);
        int         region;
        int         lat;
        int         kind;
        bit         ack;
        bit         we;
        logic [1:0] mask;
        logic [3:0] exp;
        region = int'(byteAddr[15:12]);
        lat    = latencyOf(region);
        kind   = kindOf(region);
        mask   = {!udsIn, !ldsIn};
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            checkOutput("idleOuts", 16'(busOuts()), 16'(4'b1110));
            inDone = 1'b0;
        end
        bus.as_n  = 1'b0;
        bus.addr  = byteAddr[23:1];
        bus.rw    = rwIn;
        bus.uds_n = udsIn;
        bus.lds_n = ldsIn;
        #1;
        checkOutput("select", 16'(selOuts()), 16'(expSel(region)));
        if (inDone) begin
            @(posedge clk); #1;
            checkOutput("doneSkipOuts", 16'(busOuts()), 16'(4'b1110));
            inDone = 1'b0;
        end
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            ack = (k >= lat);
            we  = (k == lat) && (region == 1) && !rwIn;
            exp = {!(ack && kind == KIND_DTACK), !(ack && kind == KIND_VPA),
                   !(ack && kind == KIND_BERR), we};
            checkOutput($sformatf("cycleOuts r%0d k%0d", region, k), 16'(busOuts()), 16'(exp));
            if (k == hold) begin
                checkOutput("ramMask", 16'(bus.ram_mask), 16'(mask));
            end
            bus.rw    = 1'($urandom);
            bus.uds_n = 1'($urandom);
            bus.lds_n = 1'($urandom);
        end
        bus.as_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("doneOuts", 16'(busOuts()), 16'(4'b1110));
        checkOutput("doneSelect", 16'(selOuts()), 16'(5'b00000));
        inDone = 1'b1;
    endtask

    initial begin
        logic [23:0] a;
        int          region;
        int          hold;
        bus.as_n  = 1'b1;
        bus.rw    = 1'b1;
        bus.uds_n = 1'b1;
        bus.lds_n = 1'b1;
        bus.addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOuts", 16'(busOuts()), 16'(4'b1110));
        checkOutput("resetMask", 16'(bus.ram_mask), 16'(2'b00));
        rst_n = 1'b1;

        applyStimulus(24'h000100, 1'b1, 1'b0, 1'b0, 3, 1);
        applyStimulus(24'h001002, 1'b0, 1'b0, 1'b1, 6, 1);
        applyStimulus(24'h003000, 1'b1, 1'b0, 1'b0, 3, 0);
        applyStimulus(24'h008000, 1'b1, 1'b0, 1'b0, 19, 2);
        applyStimulus(24'h001000, 1'b0, 1'b0, 1'b0, 2, 1);
        applyStimulus(24'h001004, 1'b0, 1'b1, 1'b0, 5, 0);

        // Asynchronous reset while the ROM cycle is acknowledged.
        repeat (2) @(posedge clk);
        #1;
        bus.addr  = 23'h000080;
        bus.rw    = 1'b1;
        bus.uds_n = 1'b0;
        bus.lds_n = 1'b0;
        bus.as_n  = 1'b0;
        @(posedge clk); #1;
        checkOutput("preRstDtack", 16'(bus.dtack_n), 16'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstDtack", 16'(bus.dtack_n), 16'(1'b1));
        checkOutput("asyncRstMask", 16'(bus.ram_mask), 16'(2'b00));
        bus.as_n = 1'b1;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        inDone = 1'b0;
        applyStimulus(24'h000200, 1'b1, 1'b1, 1'b0, 2, 0);

        for (int t = 0; t < 50; t++) begin
            region = int'($urandom_range(0, 7));
            if (region > 4) region = int'($urandom_range(5, 15));
            a        = 24'($urandom);
            a[15:12] = 4'(region);
            a[0]     = 1'b0;
            hold     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 20))
                                                   : int'($urandom_range(1, 6));
            applyStimulus(a, 1'($urandom), 1'($urandom), 1'($urandom), hold,
                          int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("finalIdle", 16'(busOuts()), 16'(4'b1110));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
